// File: rtl/pulse_sched_pkg.sv
// Shared types and default sizing for the rectangular-pulse sequencer.
package pulse_sched_pkg;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_AMP_W  = 3;
  localparam int DEF_PERIOD = 8;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] dur;
    logic [DEF_AMP_W-1:0] amp;
    logic [DEF_CNT_W-1:0] ofs;
  } cfg_t;
endpackage

// File: rtl/pulse_cfg_shadow.sv
// Double-buffered config: valid/ready into a pending slot, moved to the
// active slot only when the owner raises apply.
module pulse_cfg_shadow #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         apply,
  output logic [W-1:0] act_nxt
);
  logic         alive, pend;
  logic [W-1:0] pend_q, act_q;

  // alive keeps ready low while reset is held and for the release cycle
  assign in_ready = alive & ~pend;
  assign act_nxt  = (apply & pend) ? pend_q : act_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive  <= 1'b0;
      pend   <= 1'b0;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      alive <= 1'b1;
      if (apply & pend) begin
        act_q <= pend_q;
        pend  <= 1'b0;
      end
      // ready implies !pend, so a transfer never collides with an apply
      if (in_valid & in_ready) begin
        pend   <= 1'b1;
        pend_q <= in_data;
      end
    end
  end
endmodule

// File: rtl/pulse_train_scheduler.sv
// Period sequencer: FSM, phase counter, window compare and registered outputs.
module pulse_train_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int AMP_W  = DEF_AMP_W,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic [AMP_W-1:0] cfg_amp,
  input  logic [CNT_W-1:0] cfg_ofs,
  output logic [AMP_W-1:0] out_amp,
  output logic             pulse_active,
  output logic             period_start,
  output logic             running
);
  generate
    if (PERIOD < 2 || PERIOD > (1 << CNT_W)) begin : g_bad_period
      $error("pulse_train_scheduler: PERIOD out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PER     = (CNT_W+1)'(PERIOD);

  typedef struct packed {
    logic [CNT_W-1:0] dur;
    logic [AMP_W-1:0] amp;
    logic [CNT_W-1:0] ofs;
  } cfg_w_t;

  cfg_w_t           cfg_in, act;
  state_t           st, st_n;
  logic [CNT_W-1:0] ph, ph_n, ph_inc;
  logic [CNT_W:0]   win_end;
  logic             at_end, apply, run_n, pa_n;

  assign cfg_in = '{dur: cfg_dur, amp: cfg_amp, ofs: cfg_ofs};
  assign at_end = (ph == PH_LAST);
  assign apply  = (st == IDLE) | at_end;
  assign ph_inc = at_end ? '0 : ph + CNT_W'(1);

  pulse_cfg_shadow #(.W($bits(cfg_w_t))) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .in_valid (cfg_valid),
    .in_ready (cfg_ready),
    .in_data  (cfg_in),
    .apply    (apply),
    .act_nxt  (act)
  );

  always_comb begin
    st_n = st;
    ph_n = '0;
    unique case (st)
      IDLE: st_n = en ? RUN : IDLE;
      RUN: begin
        ph_n = ph_inc;
        if (!en) st_n = STOP;
      end
      STOP: begin
        ph_n = ph_inc;
        if (at_end) st_n = en ? RUN : IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  // window evaluated on next-state phase and next active config so the
  // registered outputs line up with ph
  assign run_n   = (st_n != IDLE);
  assign win_end = {1'b0, act.ofs} + {1'b0, act.dur};
  assign pa_n    = run_n & (ph_n >= act.ofs) & ({1'b0, ph_n} < win_end)
                 & ({1'b0, ph_n} < PER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      ph           <= '0;
      running      <= 1'b0;
      pulse_active <= 1'b0;
      out_amp      <= '0;
      period_start <= 1'b0;
    end else begin
      st           <= st_n;
      ph           <= ph_n;
      running      <= run_n;
      pulse_active <= pa_n;
      out_amp      <= pa_n ? act.amp : '0;
      period_start <= run_n & (ph_n == '0);
    end
  end
endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Directed bench for pulse_train_scheduler with hand-computed period patterns.
module tb_pulse_train_scheduler;
  logic       clk, rst, en, cfg_valid;
  logic       cfg_ready, pulse_active, period_start, running;
  logic [3:0] cfg_dur, cfg_ofs;
  logic [2:0] cfg_amp, out_amp;

  int n_chk = 0;
  int n_err = 0;
  bit drop = 0;
  bit exp_pend = 0;

  int P_BASIC[8] = '{0, 0, 5, 5, 5, 0, 0, 0};
  int P_B2[8]    = '{3, 3, 0, 0, 0, 0, 0, 0};
  int P_B3[8]    = '{0, 7, 7, 7, 7, 0, 0, 0};
  int P_CLIP[8]  = '{0, 0, 0, 0, 0, 0, 2, 2};
  int P_ZERO[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};

  pulse_train_scheduler #(.CNT_W(4), .AMP_W(3), .PERIOD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_dur      (cfg_dur),
    .cfg_amp      (cfg_amp),
    .cfg_ofs      (cfg_ofs),
    .out_amp      (out_amp),
    .pulse_active (pulse_active),
    .period_start (period_start),
    .running      (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int a, input int o);
    cfg_dur = 4'(d);
    cfg_amp = 3'(a);
    cfg_ofs = 4'(o);
  endtask

  // Runs one 8-cycle period; optionally offers a config at phase ld_ph
  // and drops en at phase off_ph.
  task automatic run_period(input string tag, input int e[8], input int ld_ph,
                            input int d, input int a, input int o, input int off_ph);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) exp_pend = 0;
      if (drop) begin
        cfg_valid = 0;
        drop      = 0;
        exp_pend  = 1;
      end
      chk($sformatf("%s_amp%0d", tag, i), out_amp, e[i]);
      chk($sformatf("%s_pa%0d", tag, i), pulse_active, (e[i] != 0) ? 1 : 0);
      chk($sformatf("%s_ps%0d", tag, i), period_start, (i == 0) ? 1 : 0);
      chk($sformatf("%s_run%0d", tag, i), running, 1);
      chk($sformatf("%s_rdy%0d", tag, i), cfg_ready, exp_pend ? 0 : 1);
      if (i == ld_ph) begin
        set_cfg(d, a, o);
        cfg_valid = 1;
        drop      = 1;
      end
      if (i == off_ph) en = 0;
    end
  endtask

  initial begin
    rst = 1; en = 0; cfg_valid = 0;
    set_cfg(0, 0, 0);
    repeat (2) tick();
    chk("rst_amp", out_amp, 0);
    chk("rst_pa", pulse_active, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_run", running, 0);
    chk("rst_rdy", cfg_ready, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("rel_rdy", cfg_ready, 1);

    // basic: load in IDLE, applied on the following edge
    set_cfg(3, 5, 2);
    cfg_valid = 1;
    tick();
    cfg_valid = 0;
    chk("ld_rdy_lo", cfg_ready, 0);
    tick();
    chk("ld_rdy_hi", cfg_ready, 1);
    chk("ld_idle_run", running, 0);
    en = 1;
    run_period("p1", P_BASIC, -1, 0, 0, 0, -1);
    run_period("p2", P_BASIC, 7, 2, 3, 0, -1);
    run_period("p3", P_BASIC, -1, 0, 0, 0, -1);
    // boundary update: transfer while ph=3, takes effect next period
    run_period("p4", P_B2, 3, 4, 7, 1, -1);
    run_period("p5", P_B3, 7, 5, 2, 6, -1);
    run_period("p6", P_B3, -1, 0, 0, 0, -1);
    // clipping: ofs=6 dur=5 stops at end of period, ofs=9 and dur=0 never fire
    run_period("p7", P_CLIP, 7, 4, 6, 9, -1);
    run_period("p8", P_CLIP, -1, 0, 0, 0, -1);
    run_period("p9", P_ZERO, 7, 0, 6, 1, -1);
    run_period("p10", P_ZERO, -1, 0, 0, 0, -1);
    run_period("p11", P_ZERO, 7, 3, 5, 2, -1);
    run_period("p12", P_ZERO, -1, 0, 0, 0, -1);
    // stop: en dropped at ph=2, period completes
    run_period("stop", P_BASIC, -1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_run%0d", i), running, 0);
      chk($sformatf("idle_amp%0d", i), out_amp, 0);
      chk($sformatf("idle_ps%0d", i), period_start, 0);
      chk($sformatf("idle_pa%0d", i), pulse_active, 0);
    end

    // back-pressure: second config held until first is applied
    set_cfg(1, 1, 0);
    cfg_valid = 1;
    tick();
    chk("bp_rdy0", cfg_ready, 0);
    set_cfg(3, 5, 2);
    tick();
    chk("bp_rdy1", cfg_ready, 1);
    tick();
    cfg_valid = 0;
    chk("bp_rdy2", cfg_ready, 0);
    tick();
    chk("bp_rdy3", cfg_ready, 1);
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_amp%0d", i), out_amp, P_BASIC[i]);
    end
    set_cfg(1, 1, 0);
    cfg_valid = 1;
    tick();
    cfg_valid = 0;
    chk("ar_pre_amp", out_amp, 5);
    chk("ar_pre_rdy", cfg_ready, 0);

    // async reset mid-pulse
    en = 0;
    #2 rst = 1;
    #1;
    chk("ar_amp", out_amp, 0);
    chk("ar_pa", pulse_active, 0);
    chk("ar_run", running, 0);
    chk("ar_rdy", cfg_ready, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("ar_rel_rdy", cfg_ready, 1);
    chk("ar_rel_run", running, 0);
    tick();
    en = 1;
    exp_pend = 0;
    run_period("post", P_ZERO, -1, 0, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
